// File: rtl/iot_result_serializer.sv
// Buffers 128-bit filter results in a small FIFO and streams each one out as
// MSB-first bytes over ready/valid. Optional `IOT_TAG_HDR_EN prefixes a tag header byte.
module iot_result_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [127:0]     in_data,
  input  logic [2:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             full,
  output logic [CNT_W-1:0] level,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef IOT_TAG_HDR_EN
  localparam logic [4:0] LAST_C = 5'd16;
`else
  localparam logic [4:0] LAST_C = 5'd15;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [127:0]       shift_q, shift_d;
  logic [4:0]         byteCnt_q, byteCnt_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;

  logic [127:0]       dataMem [DEPTH];

  logic handshake;
  logic lastByte;
  logic popHead;
  logic pushWord;
  logic dropWord;

`ifdef IOT_TAG_HDR_EN
  logic [2:0] tagMem [DEPTH];
  logic [2:0] hdrTag_q, hdrTag_d;
`else
  logic unusedTag;
  assign unusedTag = ^in_tag;
`endif

  assign handshake = (state_q == SEND) && out_ready;
  assign lastByte  = (byteCnt_q == LAST_C);
  // The head is popped either to start from idle or to chain straight after a final byte.
  assign popHead   = (level_q != '0) && ((state_q == IDLE) || (handshake && lastByte));
  assign pushWord  = in_valid && (!full_q || popHead);
  assign dropWord  = in_valid && !pushWord;

  always_ff @(posedge clk) begin
    if (pushWord) begin
      dataMem[wrPtr_q] <= in_data;
`ifdef IOT_TAG_HDR_EN
      tagMem[wrPtr_q] <= in_tag;
`endif
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (pushWord) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popHead)  rdPtr_d = rdPtr_q + PTR_W'(1);

    case ({pushWord, popHead})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == DEPTH_C);

    // A drop on the same edge as a clear keeps the flag set.
    if (dropWord)     overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    byteCnt_d = byteCnt_q;
`ifdef IOT_TAG_HDR_EN
    hdrTag_d  = hdrTag_q;
`endif

    case (state_q)
      IDLE: begin
        if (popHead) state_d = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (lastByte) begin
            if (!popHead) state_d = IDLE;
            byteCnt_d = 5'd0;
          end else begin
            byteCnt_d = byteCnt_q + 5'd1;
`ifdef IOT_TAG_HDR_EN
            if (byteCnt_q != 5'd0) shift_d = {shift_q[119:0], 8'h00};
`else
            shift_d = {shift_q[119:0], 8'h00};
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (popHead) begin
      shift_d   = dataMem[rdPtr_q];
      byteCnt_d = 5'd0;
`ifdef IOT_TAG_HDR_EN
      hdrTag_d  = tagMem[rdPtr_q];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      byteCnt_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef IOT_TAG_HDR_EN
      hdrTag_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byteCnt_q  <= byteCnt_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
`ifdef IOT_TAG_HDR_EN
      hdrTag_q   <= hdrTag_d;
`endif
    end
  end

  always_comb begin
    out_valid = (state_q == SEND);
    out_last  = (state_q == SEND) && lastByte;
    out_data  = 8'h00;
    if (state_q == SEND) begin
`ifdef IOT_TAG_HDR_EN
      out_data = (byteCnt_q == 5'd0) ? {5'b10100, hdrTag_q} : shift_q[127:120];
`else
      out_data = shift_q[127:120];
`endif
    end
  end

  assign level    = level_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_iot_result_serializer.sv
// Directed plus randomized bench for iot_result_serializer; the reference model
// keeps a queue of stored words and a queue of pending bytes for the current frame.
module tb_iot_result_serializer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [127:0]     in_data;
  logic [2:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             full;
  logic [CNT_W-1:0] level;
  logic             overflow;
  logic             ovf_clr;

  int vectors = 0;
  int miscompares = 0;

  logic [130:0] fifoQ[$];
  logic [7:0]   byteQ[$];
  logic         mOvf = 1'b0;

  iot_result_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .full(full), .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  function automatic void loadFrame(input logic [130:0] w);
    byteQ.delete();
`ifdef IOT_TAG_HDR_EN
    byteQ.push_back({5'b10100, w[130:128]});
`endif
    for (int i = 0; i < 16; i++) byteQ.push_back(w[127 - 8*i -: 8]);
  endfunction

  // Transaction-level reference: a frame drains one byte per accepted handshake.
  function automatic void modelEdge(input logic v, input logic [127:0] d, input logic [2:0] t,
                                    input logic r, input logic clr, input logic rs);
    logic hs, lastHs, popOk, acc;
    if (rs) begin
      fifoQ.delete();
      byteQ.delete();
      mOvf = 1'b0;
      return;
    end
    hs     = (byteQ.size() > 0) && r;
    lastHs = hs && (byteQ.size() == 1);
    popOk  = (fifoQ.size() > 0) && ((byteQ.size() == 0) || lastHs);
    acc    = v && ((fifoQ.size() < DEPTH) || popOk);
    if (hs) void'(byteQ.pop_front());
    if (popOk) loadFrame(fifoQ.pop_front());
    if (acc) fifoQ.push_back({t, d});
    if (v && !acc) mOvf = 1'b1;
    else if (clr)  mOvf = 1'b0;
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", out_valid, byteQ.size() > 0);
    checkVal("out_data",  out_data,  (byteQ.size() > 0) ? byteQ[0] : 8'h00);
    checkVal("out_last",  out_last,  byteQ.size() == 1);
    checkVal("level",     level,     fifoQ.size());
    checkVal("full",      full,      fifoQ.size() == DEPTH);
    checkVal("overflow",  overflow,  mOvf);
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] d, input logic [2:0] t,
                               input logic r, input logic clr, input logic rs);
    rst = rs; in_valid = v; in_data = d; in_tag = t; out_ready = r; ovf_clr = clr;
    @(posedge clk);
    modelEdge(v, d, t, r, clr, rs);
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 3'd0, r, 1'b0, 1'b0);
  endtask

  localparam logic [127:0] WORD_A = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  initial begin
    logic found;
    logic [7:0] expHdr;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0; ovf_clr = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkVal("resetValid", out_valid, 1'b0);
    checkVal("resetLevel", level, 3'd0);

    $display("[TB] single result");
    applyStimulus(1'b1, WORD_A, 3'd0, 1'b1, 1'b0, 1'b0);
    checkVal("latencyEdge1", out_valid, 1'b0);
    applyStimulus(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkVal("latencyEdge2", out_valid, 1'b1);
    idleCycles(20, 1'b1);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, WORD_A, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, '0, 3'd0, (i % 3) == 0, 1'b0, 1'b0);
    idleCycles(5, 1'b1);

    $display("[TB] overflow");
    for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 128'(k), 3'(k), 1'b0, 1'b0, 1'b0);
    checkVal("ovfLevel", level, 3'd4);
    checkVal("ovfFull", full, 1'b1);
    checkVal("ovfFlag", overflow, 1'b1);
    idleCycles(5 * 17 + 5, 1'b1);
    applyStimulus(1'b0, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkVal("ovfCleared", overflow, 1'b0);

    $display("[TB] push on pop while full");
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, {4{32'hA5A5_0000 + 32'(k)}}, 3'd1, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (byteQ.size() == 1 && fifoQ.size() == DEPTH) found = 1'b1;
      else applyStimulus(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    checkVal("pushOnPopReached", found, 1'b1);
    applyStimulus(1'b1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 3'd3, 1'b1, 1'b0, 1'b0);
    checkVal("pushOnPopLevel", level, 3'd4);
    checkVal("pushOnPopOvf", overflow, 1'b0);
    idleCycles(6 * 17 + 5, 1'b1);

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, {4{32'h1234_5600 + 32'(k)}}, 3'd2, 1'b0, 1'b0, 1'b0);
    idleCycles(5, 1'b1);
    applyStimulus(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkVal("midResetValid", out_valid, 1'b0);
    checkVal("midResetLevel", level, 3'd0);
    checkVal("midResetOvf", overflow, 1'b0);
    applyStimulus(1'b1, WORD_A, 3'd0, 1'b1, 1'b0, 1'b0);
    idleCycles(20, 1'b1);

    $display("[TB] tag header word");
`ifdef IOT_TAG_HDR_EN
    expHdr = 8'hA6;
`else
    expHdr = 8'h00;
`endif
    applyStimulus(1'b1, 128'h0, 3'h6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkVal("firstByte", out_data, expHdr);
    idleCycles(20, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 2) == 0, {$urandom, $urandom, $urandom, $urandom},
                    3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, 1'b0);
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 1) == 0, {$urandom, $urandom, $urandom, $urandom},
                    3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
    idleCycles(120, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
